// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store controller.
package lsu_pkg;

  // Lane geometry of the 32-bit data word.
  localparam int LANE_W = 8;
  localparam int HALF_W = 16;
  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LD_RD    = 3'd1,
    LD_WAIT  = 3'd2,
    ST_WR    = 3'd3,
    RMW_RD   = 3'd4,
    RMW_WAIT = 3'd5,
    RMW_WR   = 3'd6,
    RESP     = 3'd7
  } state_e;

  // Flags an access whose size is reserved or whose low address bits are
  // not aligned to that size.
  function automatic logic size_fault(input size_e size, input logic [1:0] lo);
    logic f;
    case (size)
      SZ_BYTE: f = 1'b0;
      SZ_HALF: f = lo[0];
      SZ_WORD: f = (lo != 2'b00);
      default: f = 1'b1;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Pipeline-side request/response bus of the load/store controller.
interface lsu_ctrl_if #(
  parameter int W  = 32,
  parameter int AW = 32
);
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [1:0]    req_size;
  logic          req_unsigned;
  logic [AW-1:0] req_addr;
  logic [W-1:0]  req_wdata;
  logic          resp_valid;
  logic [W-1:0]  resp_rdata;
  logic          resp_err;

  // Execute stage side: issues requests, consumes responses.
  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  // Controller side.
  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/lsu_fmt.sv
// Combinational lane logic: load extract/extend and sub-word store merge.
module lsu_fmt
  import lsu_pkg::*;
(
  input  size_e              size_i,
  input  logic               unsigned_i,
  input  logic [1:0]         lane_i,
  input  logic [WORD_W-1:0]  rdata_i,
  input  logic [HALF_W-1:0]  wdata_i,
  output logic [WORD_W-1:0]  ld_data_o,
  output logic [WORD_W-1:0]  st_word_o
);

  logic [LANE_W-1:0] byte_s;
  logic [HALF_W-1:0] half_s;

  // Pick the addressed byte and halfword out of the memory word.
  always_comb begin
    byte_s = 8'h00;
    case (lane_i)
      2'b00:   byte_s = rdata_i[7:0];
      2'b01:   byte_s = rdata_i[15:8];
      2'b10:   byte_s = rdata_i[23:16];
      2'b11:   byte_s = rdata_i[31:24];
      default: byte_s = rdata_i[7:0];
    endcase
    if (lane_i[1]) begin
      half_s = rdata_i[31:16];
    end else begin
      half_s = rdata_i[15:0];
    end
  end

  // Right-align and sign/zero extend; words pass through untouched.
  always_comb begin
    ld_data_o = 32'h0000_0000;
    case (size_i)
      SZ_BYTE: begin
        if (unsigned_i) begin
          ld_data_o = {24'h00_0000, byte_s};
        end else begin
          ld_data_o = {{24{byte_s[7]}}, byte_s};
        end
      end
      SZ_HALF: begin
        if (unsigned_i) begin
          ld_data_o = {16'h0000, half_s};
        end else begin
          ld_data_o = {{16{half_s[15]}}, half_s};
        end
      end
      SZ_WORD: ld_data_o = rdata_i;
      default: ld_data_o = 32'h0000_0000;
    endcase
  end

  // Replace only the addressed lane of the old word with the store data.
  always_comb begin
    st_word_o = rdata_i;
    case (size_i)
      SZ_BYTE: begin
        case (lane_i)
          2'b00:   st_word_o[7:0]   = wdata_i[7:0];
          2'b01:   st_word_o[15:8]  = wdata_i[7:0];
          2'b10:   st_word_o[23:16] = wdata_i[7:0];
          2'b11:   st_word_o[31:24] = wdata_i[7:0];
          default: st_word_o        = rdata_i;
        endcase
      end
      SZ_HALF: begin
        if (lane_i[1]) begin
          st_word_o[31:16] = wdata_i;
        end else begin
          st_word_o[15:0] = wdata_i;
        end
      end
      default: st_word_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller: turns byte-addressed requests into word-indexed
// MemRead/MemWrite strobes, with read-modify-write for sub-word stores.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int W  = 32,
  parameter int N  = 5,
  parameter int AW = 32
) (
  input  logic         clk,
  input  logic         rst,
  lsu_ctrl_if.slave    bus,
  output logic [N-1:0] mem_address_o,
  output logic         mem_read_o,
  output logic         mem_write_o,
  output logic [W-1:0] mem_wdata_o,
  input  logic [W-1:0] mem_rdata_i
);

  state_e       state_q, state_d;
  size_e        size_q;
  logic         uns_q;
  logic [1:0]   lane_q;
  logic [15:0]  wdata_q;
  logic [N-1:0] mem_address_q;
  logic [W-1:0] mem_wdata_q;
  logic         mem_read_q, mem_write_q;
  logic         resp_valid_q, resp_err_q;
  logic [W-1:0] resp_rdata_q;

  size_e        size_in_s;
  logic         accept_s, err_s;
  logic [W-1:0] ld_data_s, st_word_s;

  assign size_in_s = size_e'(bus.req_size);
  assign accept_s  = bus.req_valid && (state_q == IDLE);
  // The checks look at the request being accepted, i.e. the values latched
  // at the same edge, so the error path can reach RESP in cycle 1.
  assign err_s     = size_fault(size_in_s, bus.req_addr[1:0]) ||
                     (|(bus.req_addr >> (N + 2)));

  // Sequencing: route the accepted request down its load/store/error path.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (!accept_s) begin
          state_d = IDLE;
        end else if (err_s) begin
          state_d = RESP;
        end else if (!bus.req_we) begin
          state_d = LD_RD;
        end else if (size_in_s == SZ_WORD) begin
          state_d = ST_WR;
        end else begin
          state_d = RMW_RD;
        end
      end
      LD_RD:    state_d = LD_WAIT;
      LD_WAIT:  state_d = RESP;
      ST_WR:    state_d = RESP;
      RMW_RD:   state_d = RMW_WAIT;
      RMW_WAIT: state_d = RMW_WR;
      RMW_WR:   state_d = RESP;
      RESP:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Request latches, registered strobes, write-data/merge word and response.
  always_ff @(posedge clk) begin
    if (rst) begin
      size_q        <= SZ_BYTE;
      uns_q         <= 1'b0;
      lane_q        <= 2'b00;
      wdata_q       <= 16'h0000;
      mem_address_q <= {N{1'b0}};
      mem_wdata_q   <= {W{1'b0}};
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_rdata_q  <= {W{1'b0}};
      resp_err_q    <= 1'b0;
    end else begin
      mem_read_q   <= (state_d == LD_RD) || (state_d == RMW_RD);
      mem_write_q  <= (state_d == ST_WR) || (state_d == RMW_WR);
      resp_valid_q <= (state_d == RESP);
      if (accept_s) begin
        size_q  <= size_in_s;
        uns_q   <= bus.req_unsigned;
        lane_q  <= bus.req_addr[1:0];
        wdata_q <= bus.req_wdata[15:0];
        // Faulting requests leave the memory-side outputs untouched.
        if (!err_s) begin
          mem_address_q <= bus.req_addr[N+1:2];
          if (bus.req_we && (size_in_s == SZ_WORD)) begin
            mem_wdata_q <= bus.req_wdata;
          end
        end
      end
      if (state_q == RMW_WAIT) begin
        mem_wdata_q <= st_word_s;
      end
      if (state_q == LD_WAIT) begin
        resp_rdata_q <= ld_data_s;
        resp_err_q   <= 1'b0;
      end else if (state_d == RESP) begin
        // Coming straight from IDLE into RESP means the request faulted.
        resp_rdata_q <= {W{1'b0}};
        resp_err_q   <= (state_q == IDLE);
      end
    end
  end

  lsu_fmt u_fmt (
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .lane_i     (lane_q),
    .rdata_i    (mem_rdata_i),
    .wdata_i    (wdata_q),
    .ld_data_o  (ld_data_s),
    .st_word_o  (st_word_s)
  );

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;
  assign mem_address_o  = mem_address_q;
  assign mem_wdata_o    = mem_wdata_q;
  // No memory access may happen while reset is held, even mid-write.
  assign mem_read_o     = mem_read_q && !rst;
  assign mem_write_o    = mem_write_q && !rst;

endmodule
